// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_seq                                                |
// | Description : Handshaked ALU; single-cycle logic/branch ops,         |
// |               bit-serial shifts and shift-add multiply.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_seq #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [W-1:0] InputA,
  input  logic [W-1:0] InputB,
  input  logic [3:0]   ALU_OP,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [W-1:0] ALU_OUT,
  output logic         Zero
);

  localparam int CNT_W = $clog2(W + 1);

  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(W);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [W-1:0]     c_w_val    = W'(W);

  localparam logic [3:0] c_op_add  = 4'd0;
  localparam logic [3:0] c_op_sub  = 4'd1;
  localparam logic [3:0] c_op_and  = 4'd2;
  localparam logic [3:0] c_op_or   = 4'd3;
  localparam logic [3:0] c_op_xor  = 4'd4;
  localparam logic [3:0] c_op_srl  = 4'd5;
  localparam logic [3:0] c_op_sll  = 4'd6;
  localparam logic [3:0] c_op_xorr = 4'd7;
  localparam logic [3:0] c_op_beq  = 4'd8;
  localparam logic [3:0] c_op_bne  = 4'd9;
  localparam logic [3:0] c_op_blt  = 4'd10;
  localparam logic [3:0] c_op_mul  = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [3:0]         r_op;
  logic [W-1:0]       r_acc;
  logic               r_zero;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_is_shift;
  logic [CNT_W-1:0]   w_shamt;
  logic [W-1:0]       w_imm_out;
  logic               w_imm_zero;

  assign w_is_shift = (ALU_OP == c_op_srl) || (ALU_OP == c_op_sll);
  // Shift amounts of W or more saturate at W steps, which clears the operand.
  assign w_shamt    = (InputB >= c_w_val) ? c_cnt_full : InputB[CNT_W-1:0];

  always_comb begin
    w_imm_out  = '0;
    w_imm_zero = 1'b0;
    case (ALU_OP)
      c_op_add:  w_imm_out = InputA + InputB;
      c_op_sub:  w_imm_out = InputA - InputB;
      c_op_and:  w_imm_out = InputA & InputB;
      c_op_or:   w_imm_out = InputA | InputB;
      c_op_xor:  w_imm_out = InputA ^ InputB;
      c_op_xorr: w_imm_out = {{(W-1){1'b0}}, ^InputA};
      c_op_beq:  w_imm_zero = (InputA == InputB);
      c_op_bne:  w_imm_zero = (InputA != InputB);
      c_op_blt:  w_imm_zero = (InputA < InputB);
      c_op_srl, c_op_sll, c_op_mul: w_imm_out = '0;
      default:   w_imm_out = W'(1);
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (InValid) begin
          if ((ALU_OP == c_op_mul) || (w_is_shift && (w_shamt != '0))) w_next = BUSY;
          else                                                         w_next = DONE;
        end
      end
      BUSY:    if (r_cnt == c_cnt_one) w_next = DONE;
      DONE:    if (OutReady) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_acc  <= '0;
      r_zero <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (InValid) begin
            r_a    <= InputA;
            r_b    <= InputB;
            r_op   <= ALU_OP;
            r_zero <= w_imm_zero;
            if (ALU_OP == c_op_mul) begin
              r_acc <= '0;
              r_cnt <= c_cnt_full;
            end else if (w_is_shift) begin
              r_acc <= InputA;
              r_cnt <= w_shamt;
            end else begin
              r_acc <= w_imm_out;
              r_cnt <= '0;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - c_cnt_one;
          case (r_op)
            c_op_srl: r_acc <= r_acc >> 1;
            c_op_sll: r_acc <= r_acc << 1;
            default: begin
              // Shift-add: r_a is the shifted multiplicand, r_b the consumed multiplier.
              if (r_b[0]) r_acc <= r_acc + r_a;
              r_a <= r_a << 1;
              r_b <= r_b >> 1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign InReady  = (r_state == IDLE);
  assign OutValid = (r_state == DONE);
  assign ALU_OUT  = r_acc;
  assign Zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alu_seq                                             |
// | Description : Scoreboard bench for alu_seq (W=8).                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_alu_seq;
  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] InputA;
  logic [W-1:0] InputB;
  logic [3:0]   ALU_OP;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] ALU_OUT;
  logic         Zero;

  alu_seq #(.W(W)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InputA(InputA), .InputB(InputB), .ALU_OP(ALU_OP),
    .OutValid(OutValid), .OutReady(OutReady), .ALU_OUT(ALU_OUT), .Zero(Zero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] out;
    logic         zero;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [2*W-1:0] p;
    e.out  = '0;
    e.zero = 1'b0;
    e.lat  = 1;
    p      = '0;
    case (op)
      4'd0: e.out = W'(a + b);
      4'd1: e.out = W'(a - b);
      4'd2: e.out = a & b;
      4'd3: e.out = a | b;
      4'd4: e.out = a ^ b;
      4'd5: begin
        if (int'(b) >= W) begin e.out = '0; e.lat = 1 + W; end
        else begin e.out = a >> b; e.lat = 1 + int'(b); end
      end
      4'd6: begin
        if (int'(b) >= W) begin e.out = '0; e.lat = 1 + W; end
        else begin e.out = a << b; e.lat = 1 + int'(b); end
      end
      4'd7: e.out = {{(W-1){1'b0}}, ^a};
      4'd8: e.zero = (a == b);
      4'd9: e.zero = (a != b);
      4'd10: e.zero = (a < b);
      4'd11: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.out = p[W-1:0];
        e.lat = 1 + W;
      end
      default: e.out = W'(1);
    endcase
    return e;
  endfunction

  task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int stall);
    int   g;
    int   lat;
    exp_t e;
    g = 0;
    @(negedge Clk);
    while (!InReady && g < 50) begin
      @(negedge Clk);
      g++;
    end
    if (g >= 50) check({tag, "_ready_timeout"}, 32'(InReady), 32'd1);
    InValid = 1'b1;
    ALU_OP  = op;
    InputA  = a;
    InputB  = b;
    sb.push_back(model(op, a, b));
    @(posedge Clk);
    @(negedge Clk);
    InputA = W'($urandom);
    InputB = W'($urandom);
    ALU_OP = 4'($urandom);
    InValid = 1'b0;
    lat = 1;
    while (!OutValid && lat < 40) begin
      check({tag, "_busy_inready"}, 32'(InReady), 32'd0);
      InValid = 1'($urandom_range(0, 1));
      InputA  = W'($urandom);
      InputB  = W'($urandom);
      ALU_OP  = 4'($urandom);
      OutReady = 1'($urandom_range(0, 1));
      @(negedge Clk);
      lat++;
    end
    e = sb.pop_front();
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_out"}, 32'(ALU_OUT), 32'(e.out));
    check({tag, "_zero"}, 32'(Zero), 32'(e.zero));
    for (int i = 0; i < stall; i++) begin
      OutReady = 1'b0;
      InValid  = 1'($urandom_range(0, 1));
      InputA   = W'($urandom);
      @(negedge Clk);
      check({tag, "_stall_out"}, 32'(ALU_OUT), 32'(e.out));
      check({tag, "_stall_valid"}, 32'(OutValid), 32'd1);
      check({tag, "_stall_inready"}, 32'(InReady), 32'd0);
    end
    // Offer a new op in the consuming cycle; it must not be taken.
    OutReady = 1'b1;
    InValid  = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check({tag, "_consumed_valid"}, 32'(OutValid), 32'd0);
    check({tag, "_consumed_inready"}, 32'(InReady), 32'd1);
    InValid  = 1'b0;
    OutReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ov_seen;
    Reset    = 1'b1;
    InValid  = 1'b0;
    OutReady = 1'b0;
    InputA   = '0;
    InputB   = '0;
    ALU_OP   = '0;
    repeat (2) @(negedge Clk);
    #1;
    check("rst_inready", 32'(InReady), 32'd1);
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_out", 32'(ALU_OUT), 32'd0);
    check("rst_zero", 32'(Zero), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    issue("add", 4'd0, 8'hF0, 8'h20, 0);
    issue("sub", 4'd1, 8'h05, 8'h07, 0);
    issue("and", 4'd2, 8'hCC, 8'hAA, 0);
    issue("or", 4'd3, 8'hC0, 8'h0A, 1);
    issue("xor", 4'd4, 8'hFF, 8'h0F, 0);
    issue("xorr", 4'd7, 8'h07, 8'h00, 0);
    issue("sll3", 4'd6, 8'h01, 8'd3, 0);
    issue("srl9", 4'd5, 8'h80, 8'd9, 0);
    issue("srl0", 4'd5, 8'hF0, 8'd0, 0);
    issue("sll8", 4'd6, 8'h81, 8'd8, 0);
    issue("srl7", 4'd5, 8'h80, 8'd7, 0);
    issue("mul", 4'd11, 8'd13, 8'd21, 5);
    issue("mulmax", 4'd11, 8'hFF, 8'hFF, 0);
    issue("blt", 4'd10, 8'd3, 8'd5, 0);
    issue("blt_eq", 4'd10, 8'd5, 8'd5, 0);
    issue("beq", 4'd8, 8'd3, 8'd5, 0);
    issue("beq_eq", 4'd8, 8'd7, 8'd7, 0);
    issue("bne", 4'd9, 8'd3, 8'd5, 0);
    issue("undef", 4'd14, 8'h55, 8'h66, 0);

    // Abort a multiply mid-flight with an asynchronous reset pulse.
    @(negedge Clk);
    InValid = 1'b1;
    ALU_OP  = 4'd11;
    InputA  = 8'd13;
    InputB  = 8'd21;
    sb.push_back(model(4'd11, 8'd13, 8'd21));
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0;
    repeat (3) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("abort_inready", 32'(InReady), 32'd1);
    check("abort_outvalid", 32'(OutValid), 32'd0);
    check("abort_out", 32'(ALU_OUT), 32'd0);
    check("abort_zero", 32'(Zero), 32'd0);
    void'(sb.pop_front());
    @(negedge Clk);
    Reset = 1'b0;
    ov_seen = 0;
    repeat (12) begin
      @(negedge Clk);
      if (OutValid) ov_seen++;
    end
    check("abort_no_outvalid", 32'(ov_seen), 32'd0);
    issue("post_rst_add", 4'd0, 8'd1, 8'd1, 0);

    for (int k = 0; k < 8; k++) begin
      issue("rand", 4'($urandom_range(0, 15)), W'($urandom), W'($urandom_range(0, 10)),
            int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
